adc_moving_average: RTL and testbench
=====================================

Name: adc_moving_average

Overview:
- Downstream consumer of the 12-bit ADC serial receiver.
- Takes each completed sample (12-bit word plus its done strobe) and keeps a sliding window of the last 2^LOG2_DEPTH samples in a circular register buffer with a running sum.
- Emits the rounded window mean with a one-cycle valid pulse, for the display and DAC stages that follow.

Parameters:
- WIDTH, 12: sample and average width in bits.
- LOG2_DEPTH, 3: log2 of window length (DEPTH = 2^LOG2_DEPTH = 8). Legal range 1..6.

Ports:
- clock44kHz  input  1  system clock, same domain as the ADC receiver.
- reset  input  1  synchronous, active-high reset.
- listo  input  1  sample-done strobe from the ADC receiver.
- Dato_sin_basura  input  WIDTH  sample value, stable while listo=1.
- clear  input  1  synchronous flush of the window.
- promedio  output  WIDTH  registered rounded window mean.
- promedio_valido  output  1  one-cycle pulse when promedio is updated and window is full.
- lleno  output  1  window full (DEPTH samples taken since reset/clear).
- muestras  output  LOG2_DEPTH+1  samples accepted since reset/clear, saturates at DEPTH.

Behaviour:
- Clock and reset: all registers update on rising clock44kHz only. reset is sampled synchronously and is active-high.
- Reset values:
  - buffer entries = 0, sum = 0, wr_ptr = 0, listo_d = 0, state = FILL.
  - promedio = 0, promedio_valido = 0, lleno = 0, muestras = 0.
- Sample accept:
  - listo_d is listo registered.
  - acc = listo & ~listo_d, i.e. rising-edge only.
  - listo held high for N cycles is exactly one sample.
- On acc:
  - old = buf[wr_ptr].
  - sum_next = sum + Dato_sin_basura - old.
  - buf[wr_ptr] <= Dato_sin_basura.
  - wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH.
- Sum width: WIDTH+LOG2_DEPTH bits, unsigned. The subtraction never underflows, because old is always included in sum.
- Average:
  - promedio <= (sum_next + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH, round half up.
  - Computed in WIDTH+LOG2_DEPTH bits; no overflow for any input.
  - Maximum result is 2^WIDTH-1.
- Latency: promedio and promedio_valido are registered one cycle after the cycle in which acc=1.
- State machine:
  - FILL:
    - Buffer entries not yet written read as 0.
    - promedio still updates on each acc (partial sum / DEPTH); promedio_valido stays 0.
    - muestras increments on each acc.
    - On the acc that makes muestras = DEPTH: state -> RUN, lleno <= 1, promedio_valido <= 1 in the same registered cycle.
  - RUN:
    - Each acc updates promedio and pulses promedio_valido for exactly one cycle.
    - lleno stays 1; muestras holds DEPTH.
- promedio holds its value between accepts.
- clear:
  - Same effect as reset on buffer, sum, wr_ptr, state, lleno, muestras, promedio and promedio_valido.
  - listo_d still updates normally.
- Priority: reset > clear > acc.
  - A sample arriving in a clear cycle is dropped.
  - A listo that is still high after clear ends is not re-accepted; a new rising edge is required.
- Reset or clear mid-window: partial data is discarded, and the next accepted sample starts a fresh FILL.
- Back-to-back accepts (listo low one cycle, high the next) must be accepted on every rising edge, with no lost samples.

Test Plan:
- Reset, then 8 samples of 100 (listo 1 cycle each) -> promedio_valido stays 0 for samples 1-7; on sample 8 +1 cycle: promedio=100, promedio_valido=1 for one cycle, lleno=1, muestras=8.
- Window full at 100, then samples 900, 900, 900, 900 -> valid pulses with promedio 200, 300, 400, 500. Check wrap-around: the oldest sample is removed each time.
- Rounding, 8 samples of 0 then one sample of 4 -> promedio=1 (8>>3). Separately, 8 zeros then one 3 -> promedio=0 (7>>3).
- Saturation, 8 samples of 4095 -> promedio=4095 and no overflow. Then 8 samples of 0 -> promedio steps down to 0 with no underflow.
- listo held high for 5 cycles -> one sample accepted, and muestras increments by exactly 1.
- clear asserted after 5 samples, in the same cycle as a listo rising edge -> that sample is dropped; muestras=0, promedio=0, lleno=0. The next 8 samples of 50 -> first valid with promedio=50.

Source files
------------

// File: rtl/adc_moving_average_if.sv
// Sample/average bus between the ADC receiver side and the moving-average filter.
interface adc_moving_average_if #(
  parameter int WIDTH      = 12,
  parameter int LOG2_DEPTH = 3
);
  logic                  listo;
  logic [WIDTH-1:0]      Dato_sin_basura;
  logic                  clear;
  logic [WIDTH-1:0]      promedio;
  logic                  promedio_valido;
  logic                  lleno;
  logic [LOG2_DEPTH:0]   muestras;

  modport master (
    output listo, Dato_sin_basura, clear,
    input  promedio, promedio_valido, lleno, muestras
  );

  modport slave (
    input  listo, Dato_sin_basura, clear,
    output promedio, promedio_valido, lleno, muestras
  );
endinterface

// File: rtl/adc_moving_average.sv
// Sliding-window mean of the last 2^LOG2_DEPTH ADC samples, with a running sum
// over a circular register buffer and a round-half-up registered average.
module adc_moving_average #(
  parameter int WIDTH      = 12,
  parameter int LOG2_DEPTH = 3
) (
  input logic                 clock44kHz,
  input logic                 reset,
  adc_moving_average_if.slave bus
);
  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int          SW    = WIDTH + LOG2_DEPTH;
  localparam int          MW    = LOG2_DEPTH + 1;
  localparam logic [SW-1:0] HALF = SW'(1) << (LOG2_DEPTH - 1);
  localparam logic [MW-1:0] LAST = MW'(DEPTH - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [SW-1:0]         sum;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic                  listo_d;
  logic [0:0]            state;

  logic                  acc;
  logic [WIDTH-1:0]      old;
  logic [SW-1:0]         sum_next;
  logic [SW-1:0]         avg_wide;

  // Unwritten entries are zero, so the outgoing value is always part of sum.
  always_comb begin
    acc      = bus.listo & ~listo_d;
    old      = mem[wr_ptr];
    sum_next = sum + SW'(bus.Dato_sin_basura) - SW'(old);
    avg_wide = (sum_next + HALF) >> LOG2_DEPTH;
  end

  // listo_d tracks listo through clear so a held strobe is not re-accepted.
  always_ff @(posedge clock44kHz) begin
    if (reset) listo_d <= 1'b0;
    else       listo_d <= bus.listo;
  end

  always_ff @(posedge clock44kHz) begin
    if (reset || bus.clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      sum                 <= '0;
      wr_ptr              <= '0;
      state               <= FILL;
      bus.promedio        <= '0;
      bus.promedio_valido <= 1'b0;
      bus.lleno           <= 1'b0;
      bus.muestras        <= '0;
    end else begin
      bus.promedio_valido <= 1'b0;
      if (acc) begin
        mem[wr_ptr]  <= bus.Dato_sin_basura;
        sum          <= sum_next;
        wr_ptr       <= wr_ptr + 1'b1;
        bus.promedio <= avg_wide[WIDTH-1:0];
        if (state == FILL) begin
          bus.muestras <= bus.muestras + 1'b1;
          if (bus.muestras == LAST) begin
            state               <= RUN;
            bus.lleno           <= 1'b1;
            bus.promedio_valido <= 1'b1;
          end
        end else begin
          bus.promedio_valido <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_moving_average.sv
// Randomized and directed bench for adc_moving_average against a queue-based
// window model, checked on every falling edge.
module tb_adc_moving_average;
  logic clock44kHz = 1'b0;
  logic reset;

  always #5 clock44kHz = ~clock44kHz;

  adc_moving_average_if #(.WIDTH(12), .LOG2_DEPTH(3)) bus ();

  adc_moving_average #(.WIDTH(12), .LOG2_DEPTH(3)) dut (
    .clock44kHz (clock44kHz),
    .reset      (reset),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: the window is literally the last up-to-8 accepted samples.
  int unsigned win[$];
  bit          m_listo_d;
  int unsigned m_prom, m_val, m_lleno, m_mues;

  always @(posedge clock44kHz) begin
    int unsigned s;
    if (reset) begin
      win.delete();
      m_listo_d = 1'b0;
      m_prom = 0; m_val = 0; m_lleno = 0; m_mues = 0;
    end else begin
      m_val = 0;
      if (bus.clear) begin
        win.delete();
        m_prom = 0; m_lleno = 0; m_mues = 0;
      end else if (bus.listo && !m_listo_d) begin
        win.push_back(int'(bus.Dato_sin_basura));
        if (win.size() > 8) void'(win.pop_front());
        s = 0;
        foreach (win[i]) s += win[i];
        m_prom = (s + 4) / 8;
        m_mues = win.size();
        if (win.size() == 8) begin
          m_lleno = 1;
          m_val   = 1;
        end
      end
      m_listo_d = bus.listo;
    end
  end

  task automatic cmp(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  always @(negedge clock44kHz) begin
    if (chk_en) begin
      cmp("promedio",        int'(bus.promedio),        int'(m_prom));
      cmp("promedio_valido", int'(bus.promedio_valido), int'(m_val));
      cmp("lleno",           int'(bus.lleno),           int'(m_lleno));
      cmp("muestras",        int'(bus.muestras),        int'(m_mues));
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int want);
    cmp({name, "_dut"}, dut_v, want);
    cmp({name, "_model"}, mdl_v, want);
  endtask

  // Tasks start and end just after a falling edge.
  task automatic send(input int v);
    bus.listo = 1'b1;
    bus.Dato_sin_basura = 12'(v);
    @(negedge clock44kHz);
    bus.listo = 1'b0;
    @(negedge clock44kHz);
  endtask

  task automatic send_chk(input string name, input int v, input int want_prom, input int want_val);
    bus.listo = 1'b1;
    bus.Dato_sin_basura = 12'(v);
    @(negedge clock44kHz);
    lit({name, "_prom"}, int'(bus.promedio), int'(m_prom), want_prom);
    lit({name, "_val"}, int'(bus.promedio_valido), int'(m_val), want_val);
    bus.listo = 1'b0;
    @(negedge clock44kHz);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clock44kHz);
    bus.clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.listo = 1'b0;
    bus.clear = 1'b0;
    bus.Dato_sin_basura = '0;
    repeat (3) @(negedge clock44kHz);
    chk_en = 1'b1;
    lit("rst_prom", int'(bus.promedio), int'(m_prom), 0);
    lit("rst_mues", int'(bus.muestras), int'(m_mues), 0);
    reset = 1'b0;
    @(negedge clock44kHz);

    for (int k = 0; k < 7; k++) send_chk("fill100", 100, 13 * 0 + ((100 * (k + 1) + 4) / 8), 0);
    send_chk("full100", 100, 100, 1);
    lit("full_lleno", int'(bus.lleno), int'(m_lleno), 1);
    lit("full_mues", int'(bus.muestras), int'(m_mues), 8);

    send_chk("wrap1", 900, 200, 1);
    send_chk("wrap2", 900, 300, 1);
    send_chk("wrap3", 900, 400, 1);
    send_chk("wrap4", 900, 500, 1);

    do_clear();
    for (int k = 0; k < 8; k++) send(0);
    send_chk("round_up", 4, 1, 1);
    do_clear();
    for (int k = 0; k < 8; k++) send(0);
    send_chk("round_down", 3, 0, 1);

    do_clear();
    for (int k = 0; k < 7; k++) send(4095);
    send_chk("sat_max", 4095, 4095, 1);
    for (int k = 1; k <= 8; k++) send_chk("sat_down", 0, (4095 * (8 - k) + 4) / 8, 1);

    do_clear();
    bus.listo = 1'b1;
    bus.Dato_sin_basura = 12'd7;
    repeat (5) @(negedge clock44kHz);
    bus.listo = 1'b0;
    @(negedge clock44kHz);
    lit("hold5_mues", int'(bus.muestras), int'(m_mues), 1);

    do_clear();
    for (int k = 0; k < 5; k++) send(10);
    bus.listo = 1'b1;
    bus.Dato_sin_basura = 12'd999;
    bus.clear = 1'b1;
    @(negedge clock44kHz);
    bus.clear = 1'b0;
    lit("clr_mues", int'(bus.muestras), int'(m_mues), 0);
    lit("clr_prom", int'(bus.promedio), int'(m_prom), 0);
    lit("clr_lleno", int'(bus.lleno), int'(m_lleno), 0);
    repeat (2) @(negedge clock44kHz);
    lit("clr_held_mues", int'(bus.muestras), int'(m_mues), 0);
    bus.listo = 1'b0;
    @(negedge clock44kHz);
    for (int k = 0; k < 7; k++) send_chk("after_clr", 50, (50 * (k + 1) + 4) / 8, 0);
    send_chk("after_clr_full", 50, 50, 1);

    for (int it = 0; it < 400; it++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_clear();
      end else if (r < 4) begin
        reset = 1'b1;
        repeat (2) @(negedge clock44kHz);
        reset = 1'b0;
      end else begin
        bus.listo = 1'b1;
        bus.Dato_sin_basura = 12'($urandom_range(0, 4095));
        bus.clear = (r < 6);
        repeat ($urandom_range(1, 3)) @(negedge clock44kHz);
        bus.clear = 1'b0;
        bus.listo = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clock44kHz);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
